// File: rtl/fft_reorder_16_if.sv
// fft_reorder_16_if: sample stream bundle between the FFT back end and the reorder buffer
interface fft_reorder_16_if #(
    parameter int W = 16
);
    logic                in_valid;
    logic                in_ready;
    logic signed [W-1:0] in_re;
    logic signed [W-1:0] in_im;
    logic                out_valid;
    logic                out_ready;
    logic signed [W-1:0] out_re;
    logic signed [W-1:0] out_im;
    logic                out_first;
    logic                out_last;

    modport master (
        output in_valid, in_re, in_im, out_ready,
        input  in_ready, out_valid, out_re, out_im, out_first, out_last
    );

    modport slave (
        input  in_valid, in_re, in_im, out_ready,
        output in_ready, out_valid, out_re, out_im, out_first, out_last
    );
endinterface

// File: rtl/fft_reorder_16.sv
// fft_reorder_16: ping-pong frame buffer turning bit-reversed FFT output into natural order
module fft_reorder_16 #(
    parameter int N     = 16,
    parameter int LOG2N = 4,
    parameter int W     = 16
) (
    input logic             clk,
    input logic             rst,
    fft_reorder_16_if.slave bus
);
    logic signed [W-1:0] mem_re_q [2*N];
    logic signed [W-1:0] mem_im_q [2*N];
    logic [LOG2N-1:0]    wcnt_q, rcnt_q, wadr;
    logic                wsel_q, rsel_q;
    logic [1:0]          full_q, full_d;
    logic                out_valid_q, out_first_q, out_last_q;
    logic signed [W-1:0] out_re_q, out_im_q;
    logic                acc, ld;

    assign acc = bus.in_valid && !full_q[wsel_q];
    assign ld  = full_q[rsel_q] && (!out_valid_q || bus.out_ready);

    assign bus.in_ready  = !full_q[wsel_q];
    assign bus.out_valid = out_valid_q;
    assign bus.out_re    = out_re_q;
    assign bus.out_im    = out_im_q;
    assign bus.out_first = out_first_q;
    assign bus.out_last  = out_last_q;

    // write address is the bit-reversed arrival count, so reads can walk linearly
    always_comb begin
        wadr = '0;
        for (int i = 0; i < LOG2N; i++) wadr[i] = wcnt_q[LOG2N-1-i];
    end

    // a bank fills on its last write and frees as its last entry moves to the output register
    always_comb begin
        full_d = full_q;
        if (acc && &wcnt_q) full_d[wsel_q] = 1'b1;
        if (ld && &rcnt_q) full_d[rsel_q] = 1'b0;
    end

    // sample storage, deliberately not reset
    always_ff @(posedge clk) begin
        if (acc) begin
            mem_re_q[{wsel_q, wadr}] <= bus.in_re;
            mem_im_q[{wsel_q, wadr}] <= bus.in_im;
        end
    end

    // bank bookkeeping and the registered output stage
    always_ff @(posedge clk) begin
        if (rst) begin
            wcnt_q      <= '0;
            rcnt_q      <= '0;
            wsel_q      <= 1'b0;
            rsel_q      <= 1'b0;
            full_q      <= '0;
            out_valid_q <= 1'b0;
            out_first_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_re_q    <= '0;
            out_im_q    <= '0;
        end else begin
            full_q <= full_d;
            if (acc) begin
                wcnt_q <= wcnt_q + 1'b1;
                if (&wcnt_q) wsel_q <= !wsel_q;
            end
            if (ld) begin
                out_re_q    <= mem_re_q[{rsel_q, rcnt_q}];
                out_im_q    <= mem_im_q[{rsel_q, rcnt_q}];
                out_first_q <= (rcnt_q == '0);
                out_last_q  <= &rcnt_q;
                out_valid_q <= 1'b1;
                rcnt_q      <= rcnt_q + 1'b1;
                if (&rcnt_q) rsel_q <= !rsel_q;
            end else if (bus.out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end
endmodule
